// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and default width.
package seq_div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] trial_s;

  // Shift in the next dividend bit and subtract when the divisor fits;
  // the difference always fits in WIDTH bits whenever it is kept.
  always_comb begin
    shifted_s = {rem, dvd_msb};
    trial_s   = shifted_s[WIDTH-1:0] - divisor;
    q_bit     = (shifted_s >= {1'b0, divisor});
    if (q_bit) begin
      next_rem = trial_s;
    end else begin
      next_rem = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: start/busy/done handshake, quotient truncates toward zero,
// remainder takes the dividend's sign, divide-by-zero flagged with q = all ones, r = a.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W     = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    COUNT_LOAD = CW'(WIDTH);

  logic [1:0]       state_r, next_state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] rem_r, dvd_r, divisor_r;
  logic             sign_q_r, sign_r_r, dbz_r;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, next_rem_s, q_fix_s, r_fix_s;
  logic             b_zero_s, q_bit_s;
  logic             busy_r, done_r, dbz_out_r;
  logic [WIDTH-1:0] q_r, r_r;

  assign a_mag_s  = a[WIDTH-1] ? (~a + ONE_W) : a;
  assign b_mag_s  = b[WIDTH-1] ? (~b + ONE_W) : b;
  assign b_zero_s = (b == ZERO_W);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .dvd_msb (dvd_r[WIDTH-1]),
    .divisor (divisor_r),
    .next_rem(next_rem_s),
    .q_bit   (q_bit_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = b_zero_s ? S_FIXUP : S_CALC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (count_r == COUNT_ONE) begin
          next_state_s = S_FIXUP;
        end else begin
          next_state_s = S_CALC;
        end
      end
      S_FIXUP: next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Result sign correction; with a zero divisor dvd_r still holds the raw dividend
  always_comb begin
    q_fix_s = ZERO_W;
    r_fix_s = ZERO_W;
    if (dbz_r) begin
      q_fix_s = ONES_W;
      r_fix_s = dvd_r;
    end else begin
      q_fix_s = sign_q_r ? (~dvd_r + ONE_W) : dvd_r;
      r_fix_s = sign_r_r ? (~rem_r + ONE_W) : rem_r;
    end
  end

  // Operand capture and the iterative datapath; dvd_r accumulates quotient bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= COUNT_ZERO;
      rem_r     <= ZERO_W;
      dvd_r     <= ZERO_W;
      divisor_r <= ZERO_W;
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            sign_q_r  <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r_r  <= a[WIDTH-1];
            rem_r     <= ZERO_W;
            divisor_r <= b_mag_s;
            dbz_r     <= b_zero_s;
            dvd_r     <= b_zero_s ? a : a_mag_s;
            count_r   <= b_zero_s ? COUNT_ZERO : COUNT_LOAD;
          end else begin
            count_r <= count_r;
          end
        end
        S_CALC: begin
          rem_r   <= next_rem_s;
          dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
          count_r <= count_r - COUNT_ONE;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Registered handshake and results; results move only in the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      q_r       <= ZERO_W;
      r_r       <= ZERO_W;
      dbz_out_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != S_IDLE);
      done_r <= (state_r == S_FIXUP);
      if (state_r == S_FIXUP) begin
        q_r       <= q_fix_s;
        r_r       <= r_fix_s;
        dbz_out_r <= dbz_r;
      end else begin
        q_r <= q_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign q           = q_r;
  assign r           = r_r;
  assign div_by_zero = dbz_out_r;

endmodule
